// File: rtl/rtc_timebase.sv
// rtl/rtc_timebase.sv - sub-second tick, PPS pulse, uptime and 24 h time-of-day with load handshake and alarm
module rtc_timebase #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int PPS_WIDTH = 1,
  parameter int UPTIME_W  = 32
) (
  input  logic                       clk_50m,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       set_valid,
  output logic                       set_ready,
  input  logic [4:0]                 set_hour,
  input  logic [5:0]                 set_min,
  input  logic [5:0]                 set_sec,
  output logic                       set_err,
  input  logic                       alarm_en,
  input  logic [4:0]                 alarm_hour,
  input  logic [5:0]                 alarm_min,
  input  logic [5:0]                 alarm_sec,
  output logic                       tick,
  output logic                       pps,
  output logic [$clog2(TICK_HZ)-1:0] subsec,
  output logic [4:0]                 hour,
  output logic [5:0]                 minute,
  output logic [5:0]                 second,
  output logic [UPTIME_W-1:0]        uptime,
  output logic                       alarm_hit
);

  localparam int DIV    = CLK_FREQ / TICK_HZ;
  localparam int SUB_W  = $clog2(TICK_HZ);
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PPS_CW = $clog2(PPS_WIDTH + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(TICK_HZ - 1);
  localparam logic [PPS_CW-1:0] PPS_RELOAD = PPS_CW'(PPS_WIDTH - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [4:0]          hour_q, hour_d;
  logic [5:0]          min_q, min_d, sec_q, sec_d;
  logic [UPTIME_W-1:0] up_q, up_d;
  logic [PPS_CW-1:0]   pps_cnt_q, pps_cnt_d;
  logic                pps_q, pps_d, tick_q, tick_d;
  logic                ready_q, ready_d, err_q, err_d, hit_q, hit_d;

  logic       accept, set_ok, load, wrap, boundary, alarm_ok;
  logic [4:0] hour_n;
  logic [5:0] min_n, sec_n;

  assign accept   = set_valid & ready_q;
  assign set_ok   = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
  assign load     = accept & set_ok;
  assign wrap     = enable && (pre_q == PRE_LAST);
  assign boundary = wrap && (sub_q == SUB_LAST);
  assign alarm_ok = (alarm_hour <= 5'd23) && (alarm_min <= 6'd59) && (alarm_sec <= 6'd59);

  // Time-of-day one second ahead of the current value, used at each boundary.
  always_comb begin
    sec_n  = sec_q + 6'd1;
    min_n  = min_q;
    hour_n = hour_q;
    if (sec_q == 6'd59) begin
      sec_n = '0;
      min_n = min_q + 6'd1;
      if (min_q == 6'd59) begin
        min_n  = '0;
        hour_n = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end
    end
  end

  always_comb begin
    pre_d     = pre_q;
    sub_d     = sub_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    up_d      = up_q;
    pps_d     = pps_q;
    pps_cnt_d = pps_cnt_q;
    tick_d    = 1'b0;
    err_d     = 1'b0;
    hit_d     = 1'b0;
    ready_d   = 1'b1;

    if (enable) pre_d = wrap ? '0 : pre_q + 1'b1;
    if (wrap) begin
      tick_d = 1'b1;
      sub_d  = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
    end
    if (boundary) begin
      sec_d  = sec_n;
      min_d  = min_n;
      hour_d = hour_n;
      up_d   = up_q + UPTIME_W'(1);
      hit_d  = alarm_en && alarm_ok && !load &&
               ({hour_n, min_n, sec_n} == {alarm_hour, alarm_min, alarm_sec});
    end

    // The width countdown runs on every clock so a pulse finishes even while paused.
    if (boundary && !load) begin
      pps_d     = 1'b1;
      pps_cnt_d = PPS_RELOAD;
    end else if (pps_cnt_q != '0) begin
      pps_cnt_d = pps_cnt_q - 1'b1;
    end else begin
      pps_d = 1'b0;
    end

    // A valid load realigns the second phase and overrides a coincident boundary.
    if (load) begin
      pre_d  = '0;
      sub_d  = '0;
      tick_d = 1'b0;
      hour_d = set_hour;
      min_d  = set_min;
      sec_d  = set_sec;
    end
    if (accept) begin
      ready_d = 1'b0;
      err_d   = !set_ok;
    end
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      pre_q     <= '0;
      sub_q     <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      up_q      <= '0;
      pps_cnt_q <= '0;
      pps_q     <= 1'b0;
      tick_q    <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      sub_q     <= sub_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      up_q      <= up_d;
      pps_cnt_q <= pps_cnt_d;
      pps_q     <= pps_d;
      tick_q    <= tick_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      hit_q     <= hit_d;
    end
  end

  assign set_ready = ready_q;
  assign set_err   = err_q;
  assign tick      = tick_q;
  assign pps       = pps_q;
  assign subsec    = sub_q;
  assign hour      = hour_q;
  assign minute    = min_q;
  assign second    = sec_q;
  assign uptime    = up_q;
  assign alarm_hit = hit_q;

endmodule

// File: tb/tb_rtc_timebase.sv
// tb/tb_rtc_timebase.sv - directed self-checking bench for rtc_timebase
module tb_rtc_timebase;

  logic       clk_50m, reset_n, enable, set_valid, set_ready, set_err;
  logic [4:0] set_hour, alarm_hour, hour;
  logic [5:0] set_min, set_sec, alarm_min, alarm_sec, minute, second;
  logic       alarm_en, tick, pps, alarm_hit;
  logic [3:0] subsec;
  logic [7:0] uptime;

  int total = 0;
  int bad   = 0;
  int cyc;
  int tick_q[$];
  int exp_c;
  logic tick_mon;

  rtc_timebase #(
    .CLK_FREQ (100),
    .TICK_HZ  (10),
    .PPS_WIDTH(3),
    .UPTIME_W (8)
  ) dut (
    .clk_50m   (clk_50m),
    .reset_n   (reset_n),
    .enable    (enable),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .set_err   (set_err),
    .alarm_en  (alarm_en),
    .alarm_hour(alarm_hour),
    .alarm_min (alarm_min),
    .alarm_sec (alarm_sec),
    .tick      (tick),
    .pps       (pps),
    .subsec    (subsec),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .uptime    (uptime),
    .alarm_hit (alarm_hit)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  // Rising edges seen since reset release.
  always @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_50m);
  endtask

  task automatic load(input int h, input int m, input int s);
    set_hour  = 5'(h);
    set_min   = 6'(m);
    set_sec   = 6'(s);
    set_valid = 1'b1;
  endtask

  task automatic chk_tod(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(hour), h);
    chk({tag, "_min"},  32'(minute), m);
    chk({tag, "_sec"},  32'(second), s);
  endtask

  // Tick scoreboard: each observed tick pops the cycle at which it was expected.
  always @(negedge clk_50m) begin
    if (tick_mon && reset_n && tick === 1'b1) begin
      total++;
      assert (tick_q.size() != 0) else begin
        bad++;
        $error("FAIL tick_unexpected observed=tick at cycle %0d expected=no tick", cyc);
      end
      if (tick_q.size() != 0) begin
        exp_c = tick_q.pop_front();
        assert (cyc === exp_c) else begin
          bad++;
          $error("FAIL tick_cycle observed=%0d expected=%0d", cyc, exp_c);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; set_valid = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
    alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0; alarm_sec = '0;
    tick_mon = 1'b0;
    repeat (3) @(negedge clk_50m);

    chk("rst_tick", 32'(tick), 0);
    chk("rst_pps", 32'(pps), 0);
    chk("rst_subsec", 32'(subsec), 0);
    chk_tod("rst", 0, 0, 0);
    chk("rst_uptime", 32'(uptime), 0);
    chk("rst_ready", 32'(set_ready), 1);
    chk("rst_err", 32'(set_err), 0);
    chk("rst_alarm", 32'(alarm_hit), 0);

    // Free run
    enable = 1'b1; reset_n = 1'b1; tick_mon = 1'b1;
    for (int k = 1; k <= 10; k++) tick_q.push_back(10 * k);
    for (int i = 1; i <= 103; i++) begin
      @(negedge clk_50m);
      chk("pps_free", 32'(pps), 32'(i >= 100 && i <= 102));
      if (i == 100) begin
        chk("free_sec", 32'(second), 1);
        chk("free_uptime", 32'(uptime), 1);
        chk("free_subsec", 32'(subsec), 0);
      end
    end
    chk("tick_sb_free", tick_q.size(), 0);

    // Pause at prescaler 5 for 37 cycles
    wait_cyc(105);
    enable = 1'b0;
    tick_q.push_back(147);
    wait_cyc(120);
    chk("pause_subsec_mid", 32'(subsec), 0);
    wait_cyc(142);
    chk("pause_subsec", 32'(subsec), 0);
    chk("pause_sec", 32'(second), 1);
    chk("pause_uptime", 32'(uptime), 1);
    enable = 1'b1;
    wait_cyc(148);
    chk("tick_sb_pause", tick_q.size(), 0);
    chk("resume_subsec", 32'(subsec), 1);
    tick_mon = 1'b0;

    // Rejected load
    load(24, 0, 0);
    wait_cyc(149);
    chk("rej_err", 32'(set_err), 1);
    chk("rej_ready", 32'(set_ready), 0);
    chk_tod("rej", 0, 0, 1);
    set_valid = 1'b0;
    wait_cyc(150);
    chk("rej_err_drop", 32'(set_err), 0);
    chk("rej_ready_back", 32'(set_ready), 1);

    // Rollover from 23:59:58
    load(23, 59, 58);
    wait_cyc(151);
    chk_tod("ld", 23, 59, 58);
    chk("ld_err", 32'(set_err), 0);
    chk("ld_ready", 32'(set_ready), 0);
    chk("ld_subsec", 32'(subsec), 0);
    set_valid = 1'b0;
    wait_cyc(152);
    chk("ld_ready_back", 32'(set_ready), 1);
    wait_cyc(250);
    chk_tod("roll_a", 23, 59, 58);
    wait_cyc(251);
    chk_tod("roll_b", 23, 59, 59);
    chk("roll_b_uptime", 32'(uptime), 2);
    chk("roll_b_pps", 32'(pps), 1);
    wait_cyc(351);
    chk_tod("roll_c", 0, 0, 0);
    chk("roll_c_uptime", 32'(uptime), 3);
    chk("roll_c_err", 32'(set_err), 0);

    // Alarm armed at 00:00:02
    alarm_hour = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd2; alarm_en = 1'b1;
    load(0, 0, 0);
    for (int c = 352; c <= 553; c++) begin
      wait_cyc(c);
      if (c == 352) set_valid = 1'b0;
      chk("alarm_en_hit", 32'(alarm_hit), 32'(c == 552));
    end
    chk("alarm_uptime", 32'(uptime), 5);

    // Alarm disarmed
    alarm_en = 1'b0;
    load(0, 0, 1);
    for (int c = 554; c <= 655; c++) begin
      wait_cyc(c);
      if (c == 554) set_valid = 1'b0;
      chk("alarm_off_hit", 32'(alarm_hit), 0);
    end
    chk_tod("alarm_off", 0, 0, 2);

    // Loading the alarm time directly
    alarm_en = 1'b1;
    load(0, 0, 2);
    wait_cyc(656);
    set_valid = 1'b0;
    chk("alarm_ld_hit", 32'(alarm_hit), 0);
    chk("alarm_ld_sec", 32'(second), 2);
    wait_cyc(657);
    chk("alarm_ld_hit2", 32'(alarm_hit), 0);

    // Load coincident with a second boundary
    wait_cyc(755);
    load(12, 34, 56);
    wait_cyc(756);
    set_valid = 1'b0;
    chk_tod("coin", 12, 34, 56);
    chk("coin_uptime", 32'(uptime), 7);
    chk("coin_pps", 32'(pps), 0);
    chk("coin_ready", 32'(set_ready), 0);
    wait_cyc(757);
    chk("coin_pps2", 32'(pps), 0);
    wait_cyc(856);
    chk_tod("coin_next", 12, 34, 57);
    chk("coin_next_uptime", 32'(uptime), 8);
    chk("coin_next_pps", 32'(pps), 1);

    // Uptime wrap 255 -> 0
    wait_cyc(25556);
    chk("wrap_uptime_max", 32'(uptime), 255);
    chk_tod("wrap_a", 12, 39, 4);
    wait_cyc(25656);
    chk("wrap_uptime_zero", 32'(uptime), 0);
    chk_tod("wrap_b", 12, 39, 5);

    // Reset in the middle of a pps pulse
    wait_cyc(25657);
    chk("mid_pps_high", 32'(pps), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_pps", 32'(pps), 0);
    chk_tod("arst", 0, 0, 0);
    chk("arst_uptime", 32'(uptime), 0);
    chk("arst_ready", 32'(set_ready), 1);
    repeat (2) @(negedge clk_50m);
    reset_n = 1'b1;
    for (int i = 1; i <= 103; i++) begin
      @(negedge clk_50m);
      chk("pps_after_rst", 32'(pps), 32'(i >= 100 && i <= 102));
      if (i == 100) begin
        chk("rst2_sec", 32'(second), 1);
        chk("rst2_uptime", 32'(uptime), 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
